// File: rtl/uart_tx_frame_param.sv
// rtl/uart_tx_frame_param.sv - parametrised UART transmitter with show-ahead FIFO
module uart_tx_frame_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              clk_uart,
  input  logic [DATA_W-1:0] data,
  input  logic              tx_en,
  output logic              TXD,
  output logic              busy_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              ovf_o,
  output logic              bps_en
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_full;
  logic              r_empty;
  logic              r_ovf;

  state_t            r_state;
  logic [DATA_W-1:0] r_word;
  logic              r_par;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [1:0]        r_stop_cnt;
  logic              r_txd;
  logic              r_bps_en;

  logic              w_push;
  logic              w_frame_end;
  logic              w_pop;
  logic [LVL_W-1:0]  w_level_nxt;
  logic [DATA_W-1:0] w_head;
  logic              w_head_par;

  // Full is judged on current occupancy, so a push while full is dropped even if a pop coincides.
  assign w_push      = tx_en & ~r_full;
  assign w_frame_end = (r_state == STOP) && (r_stop_cnt == 2'(STOP_BITS));
  // A new frame starts on a tick when idle or when the last stop bit ends, and the FIFO holds a word.
  assign w_pop       = clk_uart & ~r_empty & ((r_state == IDLE) | w_frame_end);
  assign w_head      = r_mem[r_rptr];
  // Odd parity makes the total ones count odd; even parity makes it even.
  assign w_head_par  = (PARITY == 1) ? ~^w_head : ^w_head;

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + 1'b1;
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  // FIFO storage; the written word is visible at the head one cycle later.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= data;
    end
  end

  // FIFO pointers, registered level/full/empty flags and the sticky overflow flag.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_W'(FIFO_DEPTH));
      r_empty <= (w_level_nxt == '0);
      if (tx_en && r_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Frame FSM: advances only on baud ticks and drives the registered line and baud enable.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= IDLE;
      r_txd      <= 1'b1;
      r_bps_en   <= 1'b0;
      r_word     <= '0;
      r_par      <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
    end else if (clk_uart) begin
      if (w_pop) begin
        r_txd     <= 1'b0;
        r_word    <= w_head;
        r_par     <= w_head_par;
        r_bit_cnt <= '0;
        r_bps_en  <= 1'b1;
        r_state   <= DATA;
      end else begin
        case (r_state)
          IDLE: begin
            r_txd    <= 1'b1;
            r_bps_en <= 1'b0;
          end
          DATA: begin
            r_txd <= r_word[r_bit_cnt];
            if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
              r_bit_cnt  <= '0;
              r_stop_cnt <= '0;
              r_state    <= (PARITY != 0) ? PAR : STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          PAR: begin
            r_txd      <= r_par;
            r_stop_cnt <= '0;
            r_state    <= STOP;
          end
          STOP: begin
            r_txd <= 1'b1;
            if (w_frame_end) begin
              r_state  <= IDLE;
              r_bps_en <= 1'b0;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign TXD     = r_txd;
  assign busy_o  = r_full;
  assign empty_o = r_empty;
  assign level_o = r_level;
  assign ovf_o   = r_ovf;
  assign bps_en  = r_bps_en;

endmodule

// File: tb/tb_uart_tx_frame_param.sv
// tb/tb_uart_tx_frame_param.sv - randomised and directed bench for uart_tx_frame_param
module tb_uart_tx_frame_param;

  logic       clk      = 1'b0;
  logic       RSTn     = 1'b0;
  logic       clk_uart = 1'b0;
  logic       tx_en    = 1'b0;
  logic [8:0] data     = '0;

  int n_chk = 0;
  int n_err = 0;

  logic [9:0] e55 = 10'b1010101010;
  logic [9:0] ec3 = 10'b1110000110;
  logic       r1 [24];
  logic       r2 [24];
  logic       bp [24];
  logic [7:0] asm_b;
  int         n_bp;

  always #5 clk = ~clk;

  // Instance configurations: 0 = 8N1 depth 8, 1 = 8O2 depth 4, 2 = 9E1 depth 2.
  function automatic int dw_of(int g);  return (g == 2) ? 9 : 8; endfunction
  function automatic int dep_of(int g); return (g == 0) ? 8 : (g == 1) ? 4 : 2; endfunction
  function automatic int par_of(int g); return g; endfunction
  function automatic int sb_of(int g);  return (g == 1) ? 2 : 1; endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, expv);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D   = dw_of(g);
    localparam int DEP = dep_of(g);
    localparam int PR  = par_of(g);
    localparam int SB  = sb_of(g);
    localparam int LW  = $clog2(DEP) + 1;

    logic          txd;
    logic          busy;
    logic          empty;
    logic          ovf;
    logic          bps;
    logic [LW-1:0] lvl;

    uart_tx_frame_param #(
      .DATA_W(D), .FIFO_DEPTH(DEP), .PARITY(PR), .STOP_BITS(SB)
    ) u_dut (
      .clk(clk), .RSTn(RSTn), .clk_uart(clk_uart), .data(data[D-1:0]), .tx_en(tx_en),
      .TXD(txd), .busy_o(busy), .empty_o(empty), .level_o(lvl), .ovf_o(ovf), .bps_en(bps)
    );

    // Reference: word queue plus a queue of remaining line bits for the frame in flight.
    logic [8:0] q[$];
    bit         bq[$];
    bit         m_txd = 1'b1;
    bit         m_fr  = 1'b0;
    bit         m_ovf = 1'b0;

    always @(posedge clk or negedge RSTn) begin : model
      int occ;
      int ones;
      logic [8:0] w;
      if (!RSTn) begin
        q.delete();
        bq.delete();
        m_txd = 1'b1;
        m_fr  = 1'b0;
        m_ovf = 1'b0;
      end else begin
        occ = q.size();
        if (clk_uart) begin
          if (bq.size() > 0) begin
            m_txd = bq.pop_front();
          end else if (occ > 0) begin
            w = q.pop_front();
            ones = 0;
            for (int i = 0; i < D; i++) begin
              bq.push_back(w[i]);
              ones += int'(w[i]);
            end
            if (PR == 1) bq.push_back(ones % 2 == 0);
            else if (PR == 2) bq.push_back(ones % 2 == 1);
            for (int i = 0; i < SB; i++) bq.push_back(1'b1);
            m_txd = 1'b0;
            m_fr  = 1'b1;
          end else begin
            m_fr = 1'b0;
          end
        end
        if (tx_en) begin
          if (occ < DEP) q.push_back(data);
          else m_ovf = 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("i%0d_txd", g),   32'(txd),   32'(m_txd));
      chk($sformatf("i%0d_lvl", g),   32'(lvl),   32'(q.size()));
      chk($sformatf("i%0d_empty", g), 32'(empty), 32'(q.size() == 0));
      chk($sformatf("i%0d_busy", g),  32'(busy),  32'(q.size() == DEP));
      chk($sformatf("i%0d_ovf", g),   32'(ovf),   32'(m_ovf));
      chk($sformatf("i%0d_bps", g),   32'(bps),   32'(m_fr));
    end
  end

  function automatic bit all_idle();
    return g_dut[0].empty && !g_dut[0].bps && g_dut[1].empty && !g_dut[1].bps &&
           g_dut[2].empty && !g_dut[2].bps;
  endfunction

  task automatic cyc(input bit tk, input bit en, input logic [8:0] d);
    clk_uart = tk;
    tx_en    = en;
    data     = d;
    @(negedge clk);
  endtask

  task automatic tickn(input int n);
    repeat (n - 1) cyc(1'b0, 1'b0, 9'h0);
    cyc(1'b1, 1'b0, 9'h0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 400 && !all_idle()) begin
      tickn(3);
      k++;
    end
    chk("drain_done", 32'(all_idle()), 32'd1);
  endtask

  initial begin
    int gap;
    int cnt;
    bit tk;
    @(negedge clk);
    cyc(1'b0, 1'b0, 9'h0);
    cyc(1'b0, 1'b0, 9'h0);
    RSTn = 1'b1;

    // Reset state
    chk("rst_txd",   32'(g_dut[0].txd),   32'd1);
    chk("rst_lvl",   32'(g_dut[0].lvl),   32'd0);
    chk("rst_empty", 32'(g_dut[0].empty), 32'd1);
    chk("rst_busy",  32'(g_dut[0].busy),  32'd0);
    chk("rst_ovf",   32'(g_dut[0].ovf),   32'd0);
    chk("rst_bps",   32'(g_dut[0].bps),   32'd0);

    // 8N1 frame of 0x55
    cyc(1'b0, 1'b1, 9'h055);
    for (int k = 0; k < 10; k++) begin
      tickn(16);
      chk($sformatf("t1_txd%0d", k), 32'(g_dut[0].txd), 32'(e55[k]));
      chk($sformatf("t1_bps%0d", k), 32'(g_dut[0].bps), 32'd1);
      if (k == 0) chk("t1_empty", 32'(g_dut[0].empty), 32'd1);
    end
    tickn(16);
    chk("t1_end_bps", 32'(g_dut[0].bps), 32'd0);
    chk("t1_end_txd", 32'(g_dut[0].txd), 32'd1);
    drain();

    // Parity bits: odd (instance 1) and even (instance 2)
    cyc(1'b0, 1'b1, 9'h007);
    for (int k = 0; k < 13; k++) begin
      tickn(8);
      r1[k] = g_dut[1].txd;
      r2[k] = g_dut[2].txd;
    end
    chk("t2_start", 32'(r2[0]), 32'd0);
    chk("t2_odd07", 32'(r1[9]), 32'd0);
    chk("t2_even07", 32'(r2[10]), 32'd1);
    drain();
    cyc(1'b0, 1'b1, 9'h000);
    for (int k = 0; k < 13; k++) begin
      tickn(8);
      r1[k] = g_dut[1].txd;
      r2[k] = g_dut[2].txd;
    end
    chk("t2_odd00", 32'(r1[9]), 32'd1);
    chk("t2_even00", 32'(r2[10]), 32'd0);
    drain();

    // Two stop bits and back-to-back frames on instance 1
    cyc(1'b0, 1'b1, 9'h0A3);
    cyc(1'b0, 1'b1, 9'h03C);
    for (int k = 0; k < 24; k++) begin
      tickn(8);
      r1[k] = g_dut[1].txd;
      bp[k] = g_dut[1].bps;
    end
    for (int i = 0; i < 8; i++) asm_b[i] = r1[1 + i];
    chk("t3_data1", 32'(asm_b), 32'h0A3);
    chk("t3_stop1", 32'(r1[10]), 32'd1);
    chk("t3_stop2", 32'(r1[11]), 32'd1);
    chk("t3_start2", 32'(r1[12]), 32'd0);
    for (int i = 0; i < 8; i++) asm_b[i] = r1[13 + i];
    chk("t3_data2", 32'(asm_b), 32'h03C);
    chk("t3_par2", 32'(r1[21]), 32'd1);
    n_bp = 0;
    for (int k = 0; k < 24; k++) n_bp += int'(bp[k]);
    chk("t3_bps_held", 32'(n_bp), 32'd24);
    drain();

    // Overflow with ticks held low
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 9'(8'h10 + i));
    cyc(1'b0, 1'b0, 9'h0);
    chk("t4_lvl1",  32'(g_dut[1].lvl),  32'd4);
    chk("t4_busy1", 32'(g_dut[1].busy), 32'd1);
    chk("t4_ovf1",  32'(g_dut[1].ovf),  32'd1);
    chk("t4_lvl2",  32'(g_dut[2].lvl),  32'd2);
    chk("t4_ovf2",  32'(g_dut[2].ovf),  32'd1);
    chk("t4_lvl0",  32'(g_dut[0].lvl),  32'd6);
    chk("t4_ovf0",  32'(g_dut[0].ovf),  32'd0);
    drain();
    chk("t4_ovf1_sticky", 32'(g_dut[1].ovf), 32'd1);

    // Asynchronous reset in the middle of a frame
    cyc(1'b0, 1'b1, 9'h0C3);
    cyc(1'b0, 1'b1, 9'h011);
    cyc(1'b0, 1'b1, 9'h022);
    repeat (4) tickn(16);
    cyc(1'b0, 1'b0, 9'h0);
    chk("t5_pre_txd", 32'(g_dut[0].txd), 32'd0);
    #2 RSTn = 1'b0;
    #1;
    chk("t5_txd",   32'(g_dut[0].txd),   32'd1);
    chk("t5_lvl",   32'(g_dut[0].lvl),   32'd0);
    chk("t5_empty", 32'(g_dut[0].empty), 32'd1);
    chk("t5_ovf",   32'(g_dut[1].ovf),   32'd0);
    chk("t5_bps",   32'(g_dut[0].bps),   32'd0);
    @(negedge clk);
    @(negedge clk);
    RSTn = 1'b1;
    cyc(1'b0, 1'b1, 9'h0C3);
    for (int k = 0; k < 10; k++) begin
      tickn(16);
      chk($sformatf("t5_txd%0d", k), 32'(g_dut[0].txd), 32'(ec3[k]));
    end
    drain();

    // Push into empty FIFO coincident with a tick
    cyc(1'b1, 1'b1, 9'h081);
    chk("t6_no_start", 32'(g_dut[0].txd), 32'd1);
    chk("t6_bps_low",  32'(g_dut[0].bps), 32'd0);
    chk("t6_lvl",      32'(g_dut[0].lvl), 32'd1);
    tickn(16);
    chk("t6_start",    32'(g_dut[0].txd), 32'd0);
    chk("t6_bps_high", 32'(g_dut[0].bps), 32'd1);
    drain();

    // Randomised traffic and tick spacing, checked every cycle by the models
    gap = $urandom_range(1, 20);
    cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      tk = 1'b0;
      cnt++;
      if (cnt >= gap) begin
        tk  = 1'b1;
        cnt = 0;
        gap = $urandom_range(1, 20);
      end
      cyc(tk, ($urandom_range(0, 23) == 0), 9'($urandom_range(0, 511)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
